// File: rtl/pause_ctrl.sv
// ---------------------------------------------------------------------------
// pause_ctrl
//   Hazard and stall controller for the 16-bit five-stage pipeline. Watches
//   the ID, EXE and MEM stages and drives the pause/flush/bubble inputs of
//   the PC, IF/ID, ID/EXE and EXE/MEM registers.
//
//   Hazard classes, in priority order while running:
//     memory wait (bounded by MEM_WAIT_MAX), jump + structural conflict,
//     jump, load-use, structural conflict (shared instruction/data RAM).
//
//   Compile-time option:
//     PAUSE_CTRL_STRUCT_HAZARD_EN  defined   -> structural-conflict rules are
//                                              active (shared RAM build)
//                                  undefined -> em_inst_ram_access ignored
//
// Ports
//   clk_50MHz            system clock
//   rst                  synchronous active-high reset
//   id_rs_a/_used        ID-stage source A and its read-enable
//   id_rs_b/_used        ID-stage source B and its read-enable
//   ie_load, ie_wb_addr  EXE-stage load and its destination register
//   ie_jump              jump taken and resolved in EXE this cycle
//   em_inst_ram_access   MEM stage uses the instruction RAM this cycle
//   mem_busy             memory/peripheral cannot complete this cycle
//   pc_PAUSE .. em_BUBBLE  combinational pipeline controls (act next edge)
//   mem_timeout          sticky: a memory wait was abandoned
//   load_stall_cnt       saturating count of load-use stalls
// ---------------------------------------------------------------------------
module pause_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int REG_ADDR_W   = 4
) (
    input  logic                  clk_50MHz,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs_a,
    input  logic                  id_rs_a_used,
    input  logic [REG_ADDR_W-1:0] id_rs_b,
    input  logic                  id_rs_b_used,
    input  logic                  ie_load,
    input  logic [REG_ADDR_W-1:0] ie_wb_addr,
    input  logic                  ie_jump,
    input  logic                  em_inst_ram_access,
    input  logic                  mem_busy,
    output logic                  pc_PAUSE,
    output logic                  ii_PAUSE,
    output logic                  ii_FLUSH,
    output logic                  ie_PAUSE,
    output logic                  ie_BUBBLE,
    output logic                  em_PAUSE,
    output logic                  em_BUBBLE,
    output logic                  mem_timeout,
    output logic [15:0]           load_stall_cnt
);

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic        mem_timeout_reg;
    logic [15:0] load_stall_cnt_reg;

    logic        struct_access;
    logic        load_use;
    logic        run_rules;
    logic        timeout_set;
    logic        stall_count;

`ifdef PAUSE_CTRL_STRUCT_HAZARD_EN
    assign struct_access = em_inst_ram_access;
`else
    // Split-RAM build: the MEM stage can never steal the fetch port.
    logic unused_em_access;
    assign unused_em_access = em_inst_ram_access;
    assign struct_access    = 1'b0;
`endif

    // Every register code is compared, including R0.
    assign load_use = ie_load &&
                      ((id_rs_a_used && (id_rs_a == ie_wb_addr)) ||
                       (id_rs_b_used && (id_rs_b == ie_wb_addr)));

    always_comb begin
        pc_PAUSE      = 1'b0;
        ii_PAUSE      = 1'b0;
        ii_FLUSH      = 1'b0;
        ie_PAUSE      = 1'b0;
        ie_BUBBLE     = 1'b0;
        em_PAUSE      = 1'b0;
        em_BUBBLE     = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        run_rules     = 1'b0;
        timeout_set   = 1'b0;
        stall_count   = 1'b0;

        case (state_reg)
            RUN: begin
                if (mem_busy) begin
                    pc_PAUSE      = 1'b1;
                    ii_PAUSE      = 1'b1;
                    ie_PAUSE      = 1'b1;
                    em_PAUSE      = 1'b1;
                    wait_cnt_next = 8'd1;
                    state_next    = MEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    if (wait_cnt_reg < WAIT_MAX) begin
                        pc_PAUSE      = 1'b1;
                        ii_PAUSE      = 1'b1;
                        ie_PAUSE      = 1'b1;
                        em_PAUSE      = 1'b1;
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end else begin
                        // Give up: drop the stuck MEM instruction as a NOP
                        // while the front of the pipe is still held.
                        pc_PAUSE      = 1'b1;
                        ii_PAUSE      = 1'b1;
                        ie_PAUSE      = 1'b1;
                        em_BUBBLE     = 1'b1;
                        timeout_set   = 1'b1;
                        wait_cnt_next = 8'd0;
                        state_next    = RUN;
                    end
                end else begin
                    // Memory released: the remaining hazards are resolved
                    // in this same cycle rather than costing an extra one.
                    run_rules     = 1'b1;
                    wait_cnt_next = 8'd0;
                    state_next    = RUN;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = 8'd0;
            end
        endcase

        if (run_rules) begin
            if (ie_jump && struct_access) begin
                // Jump held in EXE one more cycle; its flush comes next time.
                pc_PAUSE  = 1'b1;
                ii_FLUSH  = 1'b1;
                ie_PAUSE  = 1'b1;
                em_BUBBLE = 1'b1;
            end else if (ie_jump) begin
                ii_FLUSH  = 1'b1;
                ie_BUBBLE = 1'b1;
            end else if (load_use) begin
                pc_PAUSE    = 1'b1;
                ii_PAUSE    = 1'b1;
                ie_BUBBLE   = 1'b1;
                stall_count = 1'b1;
            end else if (struct_access) begin
                pc_PAUSE = 1'b1;
                ii_FLUSH = 1'b1;
            end
        end

        if (ii_FLUSH) begin
            ii_PAUSE = 1'b0;
        end

        if (rst) begin
            pc_PAUSE  = 1'b0;
            ii_PAUSE  = 1'b0;
            ii_FLUSH  = 1'b0;
            ie_PAUSE  = 1'b0;
            ie_BUBBLE = 1'b0;
            em_PAUSE  = 1'b0;
            em_BUBBLE = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_reg          <= RUN;
            wait_cnt_reg       <= 8'd0;
            mem_timeout_reg    <= 1'b0;
            load_stall_cnt_reg <= 16'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (timeout_set) begin
                mem_timeout_reg <= 1'b1;
            end
            if (stall_count && (load_stall_cnt_reg != 16'hFFFF)) begin
                load_stall_cnt_reg <= load_stall_cnt_reg + 16'd1;
            end
        end
    end

    assign mem_timeout    = mem_timeout_reg;
    assign load_stall_cnt = load_stall_cnt_reg;

endmodule

// File: tb/tb_pause_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pause_ctrl
//   Directed bench for pause_ctrl: a table of single-cycle RUN-state vectors
//   plus hand-written multi-cycle sequences (load-use, memory wait, timeout,
//   jump with structural conflict, reset during a wait).
//   Control outputs are compared as a packed vector
//   {pc_PAUSE, ii_PAUSE, ii_FLUSH, ie_PAUSE, ie_BUBBLE, em_PAUSE, em_BUBBLE}.
// ---------------------------------------------------------------------------
module tb_pause_ctrl;

    localparam int MAXW = 15;

    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_LU    = 7'b1100100; // pc, ii pause, ie bubble
    localparam logic [6:0] O_JMP   = 7'b0010100; // ii flush, ie bubble
    localparam logic [6:0] O_FRZ   = 7'b1101010; // all four pauses
    localparam logic [6:0] O_ABAND = 7'b1101001; // three pauses + em bubble
`ifdef PAUSE_CTRL_STRUCT_HAZARD_EN
    localparam logic [6:0] O_ST    = 7'b1010000; // pc pause, ii flush
    localparam logic [6:0] O_JST   = 7'b1011001; // pc, ii flush, ie pause, em bubble
`else
    localparam logic [6:0] O_ST    = O_NONE;
    localparam logic [6:0] O_JST   = O_JMP;
`endif

    logic        clk_50MHz = 1'b0;
    logic        rst;
    logic [3:0]  id_rs_a, id_rs_b, ie_wb_addr;
    logic        id_rs_a_used, id_rs_b_used, ie_load, ie_jump;
    logic        em_inst_ram_access, mem_busy;
    logic        pc_PAUSE, ii_PAUSE, ii_FLUSH, ie_PAUSE, ie_BUBBLE;
    logic        em_PAUSE, em_BUBBLE, mem_timeout;
    logic [15:0] load_stall_cnt;
    logic [6:0]  outs;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    pause_ctrl #(.MEM_WAIT_MAX(MAXW), .REG_ADDR_W(4)) dut (
        .clk_50MHz          (clk_50MHz),
        .rst                (rst),
        .id_rs_a            (id_rs_a),
        .id_rs_a_used       (id_rs_a_used),
        .id_rs_b            (id_rs_b),
        .id_rs_b_used       (id_rs_b_used),
        .ie_load            (ie_load),
        .ie_wb_addr         (ie_wb_addr),
        .ie_jump            (ie_jump),
        .em_inst_ram_access (em_inst_ram_access),
        .mem_busy           (mem_busy),
        .pc_PAUSE           (pc_PAUSE),
        .ii_PAUSE           (ii_PAUSE),
        .ii_FLUSH           (ii_FLUSH),
        .ie_PAUSE           (ie_PAUSE),
        .ie_BUBBLE          (ie_BUBBLE),
        .em_PAUSE           (em_PAUSE),
        .em_BUBBLE          (em_BUBBLE),
        .mem_timeout        (mem_timeout),
        .load_stall_cnt     (load_stall_cnt)
    );

    assign outs = {pc_PAUSE, ii_PAUSE, ii_FLUSH, ie_PAUSE, ie_BUBBLE, em_PAUSE, em_BUBBLE};

    typedef struct {
        string      name;
        logic       jump;
        logic       st;
        logic       ld;
        logic [3:0] wb;
        logic [3:0] a;
        logic       au;
        logic [3:0] b;
        logic       bu;
        logic       lu;   // a load-use stall is expected (counter steps)
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Advance one clock; inputs are driven 1 time unit after the edge and
    // outputs are sampled 1 more unit later, well away from either edge.
    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs_a = 4'd0; id_rs_a_used = 1'b0;
        id_rs_b = 4'd0; id_rs_b_used = 1'b0;
        ie_load = 1'b0; ie_wb_addr = 4'd0;
        ie_jump = 1'b0; em_inst_ram_access = 1'b0; mem_busy = 1'b0;
    endtask

    initial begin
        //                name          jmp  st   ld   wb     a      au   b      bu   lu   exp
        tbl[0]  = '{"idle",          0,   0,   0,   4'd0,  4'd0,  0,   4'd0,  0,   0,   O_NONE};
        tbl[1]  = '{"lu_a_r3",       0,   0,   1,   4'd3,  4'd3,  1,   4'd0,  0,   1,   O_LU};
        tbl[2]  = '{"lu_a_unused",   0,   0,   1,   4'd3,  4'd3,  0,   4'd5,  1,   0,   O_NONE};
        tbl[3]  = '{"lu_b_r5",       0,   0,   1,   4'd5,  4'd1,  1,   4'd5,  1,   1,   O_LU};
        tbl[4]  = '{"no_load",       0,   0,   0,   4'd3,  4'd3,  1,   4'd3,  1,   0,   O_NONE};
        tbl[5]  = '{"lu_r0",         0,   0,   1,   4'd0,  4'd0,  1,   4'd7,  0,   1,   O_LU};
        tbl[6]  = '{"jump",          1,   0,   0,   4'd0,  4'd0,  0,   4'd0,  0,   0,   O_JMP};
        tbl[7]  = '{"jump_over_lu",  1,   0,   1,   4'd2,  4'd2,  1,   4'd0,  0,   0,   O_JMP};
        tbl[8]  = '{"struct",        0,   1,   0,   4'd0,  4'd0,  0,   4'd0,  0,   0,   O_ST};
        tbl[9]  = '{"jump_struct",   1,   1,   0,   4'd0,  4'd0,  0,   4'd0,  0,   0,   O_JST};
        tbl[10] = '{"lu_over_st",    0,   1,   1,   4'd4,  4'd6,  1,   4'd4,  1,   1,   O_LU};
        tbl[11] = '{"lu_t_reg",      0,   0,   1,   4'd11, 4'd2,  0,   4'd11, 1,   1,   O_LU};

        // Reset: outputs held low even with hazards present.
        idle_inputs();
        rst = 1'b1; mem_busy = 1'b1; ie_jump = 1'b1; em_inst_ram_access = 1'b1;
        tick();
        #1 chk("reset_outs", 32'(outs), 32'(O_NONE));
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("reset_cnt", 32'(load_stall_cnt), 32'd0);
        chk("reset_timeout", 32'(mem_timeout), 32'd0);

        // Table vectors, each a single cycle starting in RUN.
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            ie_jump = tbl[i].jump; em_inst_ram_access = tbl[i].st;
            ie_load = tbl[i].ld;   ie_wb_addr = tbl[i].wb;
            id_rs_a = tbl[i].a;    id_rs_a_used = tbl[i].au;
            id_rs_b = tbl[i].b;    id_rs_b_used = tbl[i].bu;
            #1 chk(tbl[i].name, 32'(outs), 32'(tbl[i].exp));
            if (tbl[i].lu) exp_cnt++;
            tick();
        end
        idle_inputs();
        #1 chk("table_stall_cnt", 32'(load_stall_cnt), 32'(exp_cnt));
        tick();

        // Load-use lasts one cycle: the bubble removes the load next cycle.
        ie_load = 1'b1; ie_wb_addr = 4'd3; id_rs_a = 4'd3; id_rs_a_used = 1'b1;
        #1 chk("lu_seq_c1", 32'(outs), 32'(O_LU));
        exp_cnt++;
        tick();
        ie_load = 1'b0;
        #1 chk("lu_seq_c2", 32'(outs), 32'(O_NONE));
        chk("lu_seq_cnt", 32'(load_stall_cnt), 32'(exp_cnt));
        idle_inputs();
        tick();

        // mem_busy for 3 cycles, released together with a jump.
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("busy3_c%0d", i + 1), 32'(outs), 32'(O_FRZ));
            tick();
        end
        mem_busy = 1'b0; ie_jump = 1'b1;
        #1 chk("busy3_release_jump", 32'(outs), 32'(O_JMP));
        chk("busy3_timeout", 32'(mem_timeout), 32'd0);
        tick();
        idle_inputs();
        #1 chk("busy3_after", 32'(outs), 32'(O_NONE));
        tick();

        // mem_busy stuck: MAXW freezes, abandon, then a fresh episode.
        mem_busy = 1'b1;
        for (int i = 0; i < MAXW; i++) begin
            #1 chk($sformatf("stuck_frz_c%0d", i + 1), 32'(outs), 32'(O_FRZ));
            tick();
        end
        #1 chk("stuck_abandon", 32'(outs), 32'(O_ABAND));
        chk("stuck_to_before", 32'(mem_timeout), 32'd0);
        tick();
        #1 chk("stuck_to_after", 32'(mem_timeout), 32'd1);
        chk("stuck_refreeze", 32'(outs), 32'(O_FRZ));
        tick();
        mem_busy = 1'b0;
        #1 chk("stuck_release", 32'(outs), 32'(O_NONE));
        tick();
        #1 chk("timeout_sticky", 32'(mem_timeout), 32'd1);

        // Jump with structural conflict, then the repeated jump.
        ie_jump = 1'b1; em_inst_ram_access = 1'b1;
        #1 chk("jst_c1", 32'(outs), 32'(O_JST));
        tick();
        em_inst_ram_access = 1'b0;
        #1 chk("jst_c2", 32'(outs), 32'(O_JMP));
        tick();
        idle_inputs();

        // Reset in the middle of a wait clears everything; the next wait
        // runs its full length, so the wait counter really restarted.
        mem_busy = 1'b1;
        repeat (6) tick();
        rst = 1'b1;
        #1 chk("rst_wait_outs", 32'(outs), 32'(O_NONE));
        tick();
        rst = 1'b0;
        #1;
        chk("rst_wait_cnt", 32'(load_stall_cnt), 32'd0);
        chk("rst_wait_timeout", 32'(mem_timeout), 32'd0);
        for (int i = 0; i < MAXW; i++) begin
            #1 chk($sformatf("rst_frz_c%0d", i + 1), 32'(outs), 32'(O_FRZ));
            tick();
        end
        #1 chk("rst_abandon", 32'(outs), 32'(O_ABAND));
        tick();
        idle_inputs();
        #1 chk("rst_final_timeout", 32'(mem_timeout), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: bench is fully directed, but never allow a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pause_ctrl.md
# pause_ctrl

Central pipeline hazard and stall controller for the 16-bit five-stage CPU. It watches the ID, EXE and MEM stages and drives the pause and flush inputs of the PC, IF/ID, ID/EXE and EXE/MEM registers. It resolves four hazard classes: slow-memory waits, taken jumps, load-use dependencies, and instruction/data RAM sharing. A small state machine bounds memory waits with a timeout.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum consecutive freeze cycles for one `mem_busy` episode. Legal range is 1 to 255.
- `REG_ADDR_W`, default 4: register-address width. Codes 0–7 are R0–R7; 8–11 are SP, IH, RA and T.

Ports (name, direction, width, meaning):
- `clk_50MHz` in 1: system clock. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `id_rs_a` in `REG_ADDR_W`: ID-stage source A.
- `id_rs_a_used` in 1: source A is read.
- `id_rs_b` in `REG_ADDR_W`: ID-stage source B.
- `id_rs_b_used` in 1: source B is read.
- `ie_load` in 1: the EXE-stage instruction is a RAM read that writes a register.
- `ie_wb_addr` in `REG_ADDR_W`: the EXE-stage destination register.
- `ie_jump` in 1: a jump was taken and resolved in EXE this cycle.
- `em_inst_ram_access` in 1: the MEM stage accesses the instruction RAM this cycle.
- `mem_busy` in 1: the memory or peripheral cannot complete this cycle.
- `pc_PAUSE` out 1: hold PC.
- `ii_PAUSE` out 1: hold IF/ID.
- `ii_FLUSH` out 1: load NOP into IF/ID.
- `ie_PAUSE` out 1: hold ID/EXE.
- `ie_BUBBLE` out 1: drives the ID/EXE bubble input, which loads the NOP op-set.
- `em_PAUSE` out 1: hold EXE/MEM.
- `em_BUBBLE` out 1: load a NOP into EXE/MEM.
- `mem_timeout` out 1: sticky flag; a wait was abandoned.
- `load_stall_cnt` out 16: count of load-use stalls, saturating.

## Operation
- Pause/flush outputs are combinational (Mealy) functions of the state and the current inputs. They act on the next `clk_50MHz` edge.
- Registered state:
  - `state` ∈ {RUN, MEM_WAIT}
  - `wait_cnt` (8 bits)
  - `mem_timeout`
  - `load_stall_cnt`
- While `rst`=1, all pause/flush outputs are 0.
- On the `rst` edge:
  - `state`=RUN
  - `wait_cnt`=0
  - `mem_timeout`=0
  - `load_stall_cnt`=0

In RUN, the first matching rule applies:
1. **Memory wait.** Condition: `mem_busy`=1. Actions:
   - Assert `pc_PAUSE`, `ii_PAUSE`, `ie_PAUSE` and `em_PAUSE`.
   - `wait_cnt`←1.
   - Go to MEM_WAIT.
2. **Jump plus structural conflict.** Condition: `ie_jump` and `em_inst_ram_access` (only when the feature is compiled in). Actions:
   - Assert `pc_PAUSE`, `ii_FLUSH`, `ie_PAUSE` and `em_BUBBLE`.
   - The jump stays in EXE and resolves again on the next cycle.
3. **Jump.** Condition: `ie_jump`. Actions: assert `ii_FLUSH` and `ie_BUBBLE`. PC loads the target normally.
4. **Load-use.** Condition: `ie_load`, `ie_wb_addr`≠R0 code... not exempt (all codes are compared), and (`id_rs_a_used` and `id_rs_a`==`ie_wb_addr`) or (`id_rs_b_used` and `id_rs_b`==`ie_wb_addr`). Actions:
   - Assert `pc_PAUSE`, `ii_PAUSE` and `ie_BUBBLE`.
   - `load_stall_cnt`+1, saturating at 0xFFFF.
5. **Structural conflict.** Condition: `em_inst_ram_access`. Actions: assert `pc_PAUSE` and `ii_FLUSH`. The instruction fetch is lost and refetched.
6. **Otherwise:** all outputs are 0.

In MEM_WAIT:
- `mem_busy`=1 and `wait_cnt`<`MEM_WAIT_MAX`:
  - Assert all four pauses.
  - `wait_cnt`+1.
- `mem_busy`=1 and `wait_cnt`==`MEM_WAIT_MAX`: abandon the wait.
  - Assert `pc_PAUSE`, `ii_PAUSE`, `ie_PAUSE` and `em_BUBBLE`.
  - `mem_timeout`←1.
  - `wait_cnt`←0.
  - Go to RUN.
- `mem_busy`=0:
  - Evaluate the RUN rules 2–6 in this same cycle (fall-through).
  - `wait_cnt`←0.
  - Go to RUN.

Additional rules:
- `mem_timeout` clears only on `rst`.
- `ii_FLUSH` takes priority over `ii_PAUSE`. The two are never asserted together.

## Timing
- Hazard detection to pause takes 0 cycles (combinational). State updates take 1 cycle.
- A load-use stall lasts exactly 1 cycle. On the next cycle `ie_load`=0 (the bubble), so the rule cannot re-fire.
- A memory freeze lasts at most `MEM_WAIT_MAX` cycles.
- `mem_busy` held high forever produces a timeout every `MEM_WAIT_MAX`+1 cycles.
- A jump plus structural conflict costs 1 extra cycle. The jump's flush occurs on the following cycle.
- `rst` asserted in MEM_WAIT returns to RUN on the next edge. No pauses are asserted while `rst`=1.

## Configuration
- `PAUSE_CTRL_STRUCT_HAZARD_EN` defined: rules 2 and 5 are active. This is for shared instruction/data RAM.
- Not defined: `em_inst_ram_access` is ignored, and rules 2 and 5 never fire. This is for split RAMs.

## Test plan
- LW with destination R3 in EXE (`ie_load`=1, `ie_wb_addr`=3), ADDU reading R3 in ID → 1 cycle of `pc_PAUSE`=`ii_PAUSE`=`ie_BUBBLE`=1, then all 0; `load_stall_cnt`=1.
- `ie_jump`=1 alone → `ii_FLUSH`=`ie_BUBBLE`=1 for 1 cycle; `pc_PAUSE`=0.
- `mem_busy` high for 3 cycles → all four pauses high for exactly 3 cycles; `mem_timeout`=0; RUN rules are evaluated on cycle 4.
- `mem_busy` stuck high with `MEM_WAIT_MAX`=15 → 15 freeze cycles; on cycle 16 `em_BUBBLE`=1 and `em_PAUSE`=0; `mem_timeout` is 1 thereafter until `rst`.
- With the macro defined, `ie_jump`=1 and `em_inst_ram_access`=1 in the same cycle → `pc_PAUSE`, `ii_FLUSH`, `ie_PAUSE` and `em_BUBBLE` for 1 cycle; the next cycle with `ie_jump`=1 → `ii_FLUSH`=`ie_BUBBLE`=1. Without the macro → plain jump response.
- `rst`=1 asserted mid-MEM_WAIT → the next cycle has all outputs 0 and `wait_cnt`=0; `load_stall_cnt` and `mem_timeout` are cleared.
